// File: rtl/uart_rx.sv
// uart_rx: UART receiver. It deframes 8N1 characters (LSB first) from an
// asynchronous serial line and presents them on a valid/ready/last byte stream.
// The last flag is recovered from line idle time after a character.
// Optional feature macro UART_RX_PARITY_EN: 8E1 framing with an rx_parity_err
// pulse; bytes with bad parity are discarded.
module uart_rx #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 115200,
  parameter int IDLE_BITS = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       UART_RX,
  output logic [7:0] rx_data,
  output logic       rx_data_valid,
  input  logic       rx_data_ready,
  output logic       rx_data_last,
  output logic       rx_frame_err,
  output logic       rx_overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic       rx_parity_err
`endif
);

  localparam int CPB      = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W    = $clog2(CPB);
  localparam int IDLE_MAX = IDLE_BITS * CPB;
  localparam int IDLE_W   = $clog2(IDLE_MAX + 1);

  localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(CPB / 2 - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(CPB - 1);
  localparam logic [IDLE_W-1:0] IDLE_SAT = IDLE_W'(IDLE_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  logic              sync1_q, rxs_q;
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [7:0]        pend_data_q, pend_data_d;
  logic              pend_valid_q, pend_valid_d;
  logic              pend_last_q, pend_last_d;
  logic [7:0]        out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;
  logic              byte_done;
  logic              out_free, idle_sat, last_now, flush;
`ifdef UART_RX_PARITY_EN
  logic              par_q, par_d;
  logic              par_err_q, par_err_d;
`endif

  // Two-flop synchroniser for the asynchronous serial line (idle high).
  // NOTE: sequential blocks use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= UART_RX;
      rxs_q   <= sync1_q;
    end
  end

  // Deframing FSM: next state, bit timing and data sampling.
  // NOTE: every signal gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    byte_done   = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d       = par_q;
    par_err_d   = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (!rxs_q) begin
          state_d   = S_START;
          cnt_d     = '0;
          bit_cnt_d = '0;
        end
      end
      S_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          // A start bit that is high again at mid-bit was only a glitch.
          state_d = rxs_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d     = '0;
          shift_d   = {rxs_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d   = '0;
          par_d   = rxs_q;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d = '0;
`ifdef UART_RX_PARITY_EN
          // Even parity: data plus parity bit must hold an even number of ones.
          par_err_d = ^{shift_q, par_q};
`endif
          if (rxs_q) begin
`ifdef UART_RX_PARITY_EN
            byte_done = ~par_err_d;
`else
            byte_done = 1'b1;
`endif
            state_d = S_IDLE;
          end else begin
            // A low stop bit may be a break; wait for the line to return high.
            frame_err_d = 1'b1;
            state_d     = S_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT_HIGH: begin
        if (rxs_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Idle timer, two-stage byte buffer (pend -> out) and packet-end recovery.
  always_comb begin
    idle_d       = idle_q;
    pend_data_d  = pend_data_q;
    pend_valid_d = pend_valid_q;
    pend_last_d  = pend_last_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    overrun_d    = 1'b0;

    if (byte_done || !(state_q inside {S_IDLE, S_WAIT_HIGH})) begin
      idle_d = '0;
    end else if (idle_q != IDLE_SAT) begin
      idle_d = idle_q + IDLE_W'(1);
    end

    out_free = !out_valid_q || rx_data_ready;
    idle_sat = (idle_q == IDLE_SAT);
    // Flush in the very cycle saturation is seen, or later once out frees up.
    last_now = pend_last_q || (pend_valid_q && idle_sat);
    flush    = pend_valid_q && last_now && out_free;

    if (out_valid_q && rx_data_ready) out_valid_d = 1'b0;

    if (flush) begin
      out_data_d   = pend_data_q;
      out_last_d   = 1'b1;
      out_valid_d  = 1'b1;
      pend_valid_d = 1'b0;
      pend_last_d  = 1'b0;
    end else if (pend_valid_q && idle_sat) begin
      pend_last_d = 1'b1;
    end

    if (byte_done) begin
      if (!pend_valid_q || flush) begin
        pend_data_d  = shift_q;
        pend_valid_d = 1'b1;
        pend_last_d  = 1'b0;
      end else if (out_free) begin
        out_data_d   = pend_data_q;
        out_last_d   = pend_last_q;
        out_valid_d  = 1'b1;
        pend_data_d  = shift_q;
        pend_last_d  = 1'b0;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // State, counters, datapath and output registers.
  // NOTE: datapath registers are reset too, so a mid-character reset leaves no stale byte behind.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      idle_q       <= '0;
      pend_data_q  <= '0;
      pend_valid_q <= 1'b0;
      pend_last_q  <= 1'b0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q        <= 1'b0;
      par_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      idle_q       <= idle_d;
      pend_data_q  <= pend_data_d;
      pend_valid_q <= pend_valid_d;
      pend_last_q  <= pend_last_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_q        <= par_d;
      par_err_q    <= par_err_d;
`endif
    end
  end

  assign rx_data       = out_data_q;
  assign rx_data_valid = out_valid_q;
  assign rx_data_last  = out_last_q;
  assign rx_frame_err  = frame_err_q;
  assign rx_overrun    = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign rx_parity_err = par_err_q;
`endif

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial-to-stream receiver; downstream counterpart of the UART transmitter.
- Samples the asynchronous UART_RX line and deframes 8N1 characters, LSB first.
- Emits bytes on a valid/ready/last stream with the same semantics as the transmitter's tx_data input, so a loopback reproduces the original packets.
- Packet boundary (last) is recovered from line idle time.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD_RATE, 115200, line bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer division, must be >= 4)
IDLE_BITS, 20, idle bit-times after a stop bit that mark the preceding byte as last of packet

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous assert, active-low (0 = reset); all flops reset on rst falling, release synchronised externally
UART_RX  in  1  serial line, idle high, asynchronous to clk
rx_data  out  8  received byte
rx_data_valid  out  1  rx_data/rx_data_last valid
rx_data_ready  in  1  consumer accepts when valid & ready on a rising edge
rx_data_last  out  1  byte is final byte of a packet
rx_frame_err  out  1  one-cycle pulse: stop bit sampled 0
rx_overrun  out  1  one-cycle pulse: received byte dropped, no buffer space

Behaviour:
- Reset values: rx_data 0, rx_data_valid 0, rx_data_last 0, rx_frame_err 0, rx_overrun 0; both synchroniser flops 1; FSM IDLE; all counters 0; pend empty.
- Input: 2-flop synchroniser on UART_RX; all decisions use the second-stage output (rxs).
- FSM states and transitions:
  - IDLE: rxs==0 -> START, bit counter cleared.
  - START: at count CLKS_PER_BIT/2-1, re-sample rxs. If rxs==0 -> DATA; if rxs==1, treat as glitch -> IDLE with no output.
  - DATA: every CLKS_PER_BIT clocks, sample rxs into shift register, LSB first. After 8 samples -> STOP.
  - STOP: CLKS_PER_BIT clocks after the last data sample, sample rxs. If 1 -> byte_done, then IDLE. If 0 -> rx_frame_err pulse, byte discarded, then WAIT_HIGH.
  - WAIT_HIGH: rxs==1 -> IDLE (a break condition never retriggers a start).
- Buffering uses two registers: pend (holding) and out (drives the ports). "out free" means rx_data_valid==0, or valid&ready in this cycle.
- Idle counter:
  - Cleared on byte_done and in any state other than IDLE/WAIT_HIGH.
  - Increments otherwise; saturates at IDLE_BITS*CLKS_PER_BIT.
  - Reaching saturation with pend full sets sticky pend_last.
- On byte_done:
  - pend empty: load pend, pend_last=0.
  - pend full and out free: move pend -> out (last = pend_last), load new byte into pend.
  - pend full and out not free: drop new byte, pulse rx_overrun; pend unchanged.
- When pend_last==1 and out free: move pend -> out with rx_data_last=1; pend empties the same cycle.
- Out register:
  - Data and last are held stable while valid & !ready.
  - rx_data_valid drops the cycle after handshake unless refilled that same cycle (back-to-back allowed).
- Latency:
  - Non-last byte appears 1 clk after the next byte's stop sample.
  - Last byte appears 1 clk after idle saturation.
- Simultaneous byte_done and pend_last-flush: flush has priority; the new byte loads pend (pend_last=0), no overrun.
- Reset mid-character: immediate return to reset state; partial byte and pend contents lost.

Optional Feature:
UART_RX_PARITY_EN:
- Defined: frame is 8E1. State PARITY sits between DATA and STOP and samples one extra bit. Even-parity mismatch pulses extra output rx_parity_err (1 bit, reset 0) at the stop sample; the byte is discarded even when the stop bit is good.
- Undefined: 8N1, no PARITY state, no rx_parity_err port.

Test Plan:
- All tests use CLK_FREQ=50000000, BAUD_RATE=5000000 (10 clks/bit), IDLE_BITS=20.
- Single byte 0xA5, ready=1 -> rx_data=0xA5, rx_data_last=1, valid for exactly 1 clk, appearing 200+1 clks after the stop-bit sample.
- Packet 0x01..0x0A back-to-back, ready=1 -> 10 bytes in order, last=1 only on 0x0A, no error pulses; loopback against the transmitter plus LFSR source gives an identical sequence.
- 3-clk low glitch on idle line -> FSM returns to IDLE, no valid, no error.
- Byte 0x3C with stop bit forced 0, line held low 30 clks -> rx_frame_err pulses once, no output, next good byte 0x55 is received correctly.
- ready=0, send 0x11,0x22,0x33 back-to-back -> 0x11 in out, 0x22 in pend, 0x33 dropped with one rx_overrun pulse; release ready -> 0x11 (last=0), 0x22 (last=1).
- rst driven low mid-DATA of 0xFF -> all outputs 0 immediately; after release, byte 0x81 is received correctly.
